serial_transmitter: RTL and testbench
=====================================

// Module: serial_transmitter
// PURPOSE
//  Serial frame transmitter; the stage directly upstream of the receiving block.
//  Accepts a parallel character plus a one-cycle load strobe. Shifts out one frame:
//  start(0), DATA_BITS data bits LSB-first, parity, stop(1).
//  Each bit is held for BIT_TICKS clocks, matching the receiver's 16x sampling.
//  serial_out drives the receiver's data_in directly.
// PARAMETERS
//  BIT_TICKS   16  clocks per serial bit (>=2)
//  DATA_BITS   7   data bits per frame; default frame = 10 bits total
//  PARITY_ODD  0   0: even parity (data^parity has even ones); 1: odd parity
// PORTS
//  clk         in   1          system clock, all logic on posedge
//  reset       in   1          synchronous, active-high
//  tx_data     in   DATA_BITS  character to send; sampled only on accepted load
//  load        in   1          start request; accepted only when busy==0
//  serial_out  out  1          serial line; idles high
//  busy        out  1          1 from cycle after accepted load until frame done
//  charSent    out  1          one-cycle pulse when stop bit completes
// BEHAVIOUR
//  Interface: one clock clk; reset is synchronous and active-high.
//  Reset (posedge clk with reset=1): state=IDLE, serial_out=1, busy=0, charSent=0,
//   tick/bit counters=0. Takes priority over everything, including mid-frame.
//   Line returns high the next cycle and the partial frame is dropped; no charSent.
//  States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//  IDLE: serial_out=1, busy=0.
//   load=1 latches tx_data into the shift register and computes parity.
//   Parity = ^tx_data ^ PARITY_ODD.
//   On the next cycle: START, serial_out=0, busy=1, tick=0.
//  Bit timing: a tick counter runs 0..BIT_TICKS-1.
//   Each bit is driven for exactly BIT_TICKS cycles.
//   At tick==BIT_TICKS-1 the next cycle moves to the next bit, tick=0.
//  START: 1 bit of 0, then DATA with bit index 0.
//  DATA: serial_out = shreg[0]; shift right at each bit end.
//   After bit DATA_BITS-1, go to PARITY.
//  PARITY: serial_out = latched parity, 1 bit, then STOP.
//  STOP: serial_out=1 for 1 bit.
//   At its last tick, the next cycle is IDLE with busy=0 and charSent=1 for exactly one cycle.
//  Latency: load accepted at cycle N -> start bit visible from N+1.
//   charSent at N+1+(DATA_BITS+3)*BIT_TICKS, which is N+161 at defaults.
//  load while busy=1: ignored. No queuing; tx_data changes have no effect mid-frame.
//  Back-to-back: load in the charSent cycle (IDLE) is accepted.
//   The next start bit follows with zero idle gap.
//  load and reset in the same cycle: reset wins, load is dropped.
//  serial_out is registered (no glitches). charSent never asserts with busy=1.
//  Counters are sized for BIT_TICKS-1 and DATA_BITS-1. No wrap except the defined tick reload.
// TESTING
//  1 Reset: reset=1 for 2 clks -> serial_out=1, busy=0, charSent=0. Line stays 1 with no load.
//  2 Frame: load tx_data=7'h4B for 1 clk -> serial_out is 0,1,1,0,1,0,0,1,0,1.
//    Each bit is held 16 clks. busy=1 for 160 clks; charSent pulses once at load+161.
//  3 Parity: tx_data=7'h01 -> parity bit 1; tx_data=7'h00 -> parity 0 (PARITY_ODD=0).
//    With PARITY_ODD=1 both parity bits invert.
//  4 Busy ignore: load 7'h4B, then load 7'h7F at load+40 -> frame unchanged.
//    Exactly one charSent pulse.
//  5 Back-to-back: assert load with 7'h55 in the charSent cycle.
//    The second start bit begins on the next clk with no idle high between frames.
//  6 Abort + loopback: reset at mid-DATA -> line 1 next clk, no charSent.
//    Then send 7'h4B into receiving -> its data_out equals the transmitted 10-bit frame.

Source files
------------

// File: rtl/serial_transmitter.sv
// Serial frame transmitter: start(0), DATA_BITS data bits LSB-first, parity, stop(1).
// Each bit is held for BIT_TICKS clocks; the line idles high.
module serial_transmitter #(
    parameter int unsigned BIT_TICKS  = 16,
    parameter int unsigned DATA_BITS  = 7,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 load,
    output logic                 serial_out,
    output logic                 busy,
    output logic                 charSent
);

    localparam int unsigned TICK_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [TICK_W-1:0]    tick;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_next;
    logic                 parity_bit;
    logic                 bit_end;

    assign bit_end    = (tick == TICK_W'(BIT_TICKS - 1));
    assign shreg_next = shreg >> 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            serial_out <= 1'b1;
            busy       <= 1'b0;
            charSent   <= 1'b0;
            tick       <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
        end else begin
            charSent <= 1'b0;
            if (state != IDLE) begin
                tick <= bit_end ? '0 : tick + TICK_W'(1);
            end

            case (state)
                IDLE: begin
                    serial_out <= 1'b1;
                    busy       <= 1'b0;
                    if (load) begin
                        shreg      <= tx_data;
                        parity_bit <= ^tx_data ^ PARITY_ODD;
                        state      <= START;
                        serial_out <= 1'b0;
                        busy       <= 1'b1;
                        tick       <= '0;
                    end
                end

                START: begin
                    if (bit_end) begin
                        state      <= DATA;
                        bit_idx    <= '0;
                        serial_out <= shreg[0];
                    end
                end

                // Output for the next bit is loaded alongside the shift so the line stays registered.
                DATA: begin
                    if (bit_end) begin
                        shreg <= shreg_next;
                        if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                            state      <= PARITY;
                            serial_out <= parity_bit;
                        end else begin
                            bit_idx    <= bit_idx + BIT_W'(1);
                            serial_out <= shreg_next[0];
                        end
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        state      <= STOP;
                        serial_out <= 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        charSent   <= 1'b1;
                        serial_out <= 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    serial_out <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench for serial_transmitter: even- and odd-parity instances share stimulus
// and are compared cycle by cycle against hand-computed 10-bit frames (bit i = i-th bit sent).
module tb_serial_transmitter;

    localparam int BT = 16;
    localparam int FB = 10;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       load    = 1'b0;
    logic [6:0] tx_data = 7'h00;
    logic       so_e, busy_e, cs_e;
    logic       so_o, busy_o, cs_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_transmitter #(.BIT_TICKS(16), .DATA_BITS(7), .PARITY_ODD(1'b0)) dut_even (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .load       (load),
        .serial_out (so_e),
        .busy       (busy_e),
        .charSent   (cs_e)
    );

    serial_transmitter #(.BIT_TICKS(16), .DATA_BITS(7), .PARITY_ODD(1'b1)) dut_odd (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .load       (load),
        .serial_out (so_o),
        .busy       (busy_o),
        .charSent   (cs_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; load is sampled by the following posedge.
    task automatic send(input logic [6:0] d);
        tx_data = d;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    // Entered at the negedge right after the accepting edge (offset 0 = start bit).
    task automatic run_frame(input logic [9:0] exp_e, input logic [9:0] exp_o,
                             input int inj_at, input bit chain, input logic [6:0] next_data);
        logic [9:0] cap_e;
        logic [9:0] cap_o;
        cap_e = '0;
        cap_o = '0;
        for (int c = 0; c < FB * BT; c++) begin
            check("line_even", 32'(so_e), 32'(exp_e[c / BT]));
            check("line_odd", 32'(so_o), 32'(exp_o[c / BT]));
            check("busy", 32'({busy_e, busy_o}), 32'h3);
            check("sent_early", 32'({cs_e, cs_o}), 32'h0);
            if (c % BT == BT / 2) begin
                cap_e[c / BT] = so_e;
                cap_o[c / BT] = so_o;
            end
            if (c == inj_at) begin
                tx_data = 7'h7F;
                load    = 1'b1;
            end else if (inj_at >= 0 && c == inj_at + 1) begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        check("frame_even", 32'(cap_e), 32'(exp_e));
        check("frame_odd", 32'(cap_o), 32'(exp_o));
        check("sent_pulse", 32'({cs_e, cs_o, busy_e, busy_o}), 32'hC);
        check("line_idle", 32'({so_e, so_o}), 32'h3);
        if (chain) begin
            send(next_data);
        end else begin
            @(negedge clk);
            check("sent_once", 32'({cs_e, cs_o}), 32'h0);
            check("line_after", 32'({so_e, so_o}), 32'h3);
        end
    endtask

    initial begin
        bit saw_low;
        bit saw_sent;

        // Reset held for two clocks, then an idle line with no load
        repeat (2) @(negedge clk);
        check("rst_line", 32'({so_e, so_o}), 32'h3);
        check("rst_busy", 32'({busy_e, busy_o}), 32'h0);
        check("rst_sent", 32'({cs_e, cs_o}), 32'h0);
        reset   = 1'b0;
        saw_low = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!so_e || !so_o || busy_e || busy_o) saw_low = 1'b1;
        end
        check("idle_hold", 32'(saw_low), 32'h0);

        // 7'h4B: 0,1,1,0,1,0,0,1,0,1 (odd parity flips bit 8)
        send(7'h4B);
        run_frame(10'h296, 10'h396, -1, 1'b0, 7'h00);

        // Parity corner cases
        send(7'h01);
        run_frame(10'h302, 10'h202, -1, 1'b0, 7'h00);
        send(7'h00);
        run_frame(10'h200, 10'h300, -1, 1'b0, 7'h00);

        // Load of 7'h7F while busy must not disturb the frame
        send(7'h4B);
        run_frame(10'h296, 10'h396, 40, 1'b0, 7'h00);

        // Back-to-back: load 7'h55 in the charSent cycle
        send(7'h4B);
        run_frame(10'h296, 10'h396, -1, 1'b1, 7'h55);
        run_frame(10'h2AA, 10'h3AA, -1, 1'b0, 7'h00);

        // Abort mid-DATA, with a simultaneous load that must be dropped
        send(7'h4B);
        repeat (49) @(negedge clk);
        check("pre_abort_busy", 32'({busy_e, busy_o}), 32'h3);
        reset   = 1'b1;
        load    = 1'b1;
        tx_data = 7'h55;
        @(negedge clk);
        reset = 1'b0;
        load  = 1'b0;
        check("abort_line", 32'({so_e, so_o}), 32'h3);
        check("abort_busy", 32'({busy_e, busy_o}), 32'h0);
        check("abort_sent", 32'({cs_e, cs_o}), 32'h0);
        saw_low  = 1'b0;
        saw_sent = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!so_e || !so_o || busy_e || busy_o) saw_low = 1'b1;
            if (cs_e || cs_o) saw_sent = 1'b1;
        end
        check("abort_quiet", 32'(saw_low), 32'h0);
        check("abort_no_sent", 32'(saw_sent), 32'h0);

        // Clean frame after abort, captured as a receiver would see it
        send(7'h4B);
        run_frame(10'h296, 10'h396, -1, 1'b0, 7'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
